wb_regfile: RTL and testbench

Write-back stage and architectural register file; consumes the memory/write-back pipeline latch outputs. Holds four 8-bit general registers (R3 doubles as stack pointer), the output-port register and the sticky halt flag. Provides two combinational read ports with same-cycle write-through bypass to decode.

---
 rtl/wb_regfile.sv | 56 +++++
 tb/tb_wb_regfile.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage with four 8-bit registers (R3 = SP), output port and sticky halt;
// two combinational read ports bypass the write being committed this cycle.
module wb_regfile #(
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] wb_ra,
  input  logic [1:0] wb_rb,
  input  logic       wb_rw,
  input  logic [1:0] wb_sp,
  input  logic       wb_sw1,
  input  logic       wb_sw2,
  input  logic       wb_out_ld,
  input  logic [7:0] wb_data,
  input  logic       wb_hlt,
  input  logic [7:0] in_port,
  input  logic [1:0] rd_a_idx,
  input  logic [1:0] rd_b_idx,
  output logic [7:0] rd_a_data,
  output logic [7:0] rd_b_data,
  output logic [7:0] sp,
  output logic [7:0] out_port,
  output logic       halted
);
  logic [7:0] r [4];
  logic [7:0] wd;
  logic [7:0] sp_next;
  logic [1:0] wdst;
  logic       ce;
  logic       we;
  assign wd   = wb_sw2 ? in_port : wb_data;
  assign wdst = wb_sw1 ? wb_rb : wb_ra;
  assign ce   = ~halted;
  assign we   = ce & wb_rw;
  assign sp   = r[3];
  assign sp_next = wb_sp == 2'b01 ? r[3] + 8'd1 : wb_sp == 2'b10 ? r[3] - 8'd1 : r[3];
  assign rd_a_data = (we && wdst == rd_a_idx) ? wd : r[rd_a_idx];
  assign rd_b_data = (we && wdst == rd_b_idx) ? wd : r[rd_b_idx];
  // The register write is issued after the SP update so it wins on R3 conflicts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r[0]     <= 8'h00;
      r[1]     <= 8'h00;
      r[2]     <= 8'h00;
      r[3]     <= SP_RESET;
      out_port <= 8'h00;
      halted   <= 1'b0;
    end else if (ce) begin
      r[3] <= sp_next;
      if (wb_rw) r[wdst] <= wd;
      if (wb_out_ld) out_port <= wb_data;
      if (wb_hlt) halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized scoreboard bench; driver pushes model expectations, monitor pops and compares.
module tb_wb_regfile;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] wb_ra = '0, wb_rb = '0, wb_sp = '0, rd_a_idx = '0, rd_b_idx = '0;
  logic       wb_rw = 1'b0, wb_sw1 = 1'b0, wb_sw2 = 1'b0, wb_out_ld = 1'b0, wb_hlt = 1'b0;
  logic [7:0] wb_data = '0, in_port = '0;
  logic [7:0] rd_a_data, rd_b_data, sp, out_port;
  logic       halted;

  wb_regfile #(.SP_RESET(8'hFF)) dut (
    .clk(clk), .reset(reset), .wb_ra(wb_ra), .wb_rb(wb_rb), .wb_rw(wb_rw), .wb_sp(wb_sp),
    .wb_sw1(wb_sw1), .wb_sw2(wb_sw2), .wb_out_ld(wb_out_ld), .wb_data(wb_data), .wb_hlt(wb_hlt),
    .in_port(in_port), .rd_a_idx(rd_a_idx), .rd_b_idx(rd_b_idx), .rd_a_data(rd_a_data),
    .rd_b_data(rd_b_data), .sp(sp), .out_port(out_port), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] o;
    logic       h;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Architectural reference state
  logic [7:0] m_r [4];
  logic [7:0] m_out;
  logic       m_h;

  function automatic logic [7:0] ref_read(input logic [1:0] idx, input logic rw,
                                          input logic [1:0] dst, input logic [7:0] wd);
    return (!m_h && rw && dst == idx) ? wd : m_r[idx];
  endfunction

  task automatic step(input logic [1:0] ra, input logic [1:0] rb, input logic rw,
                      input logic [1:0] spop, input logic sw1, input logic sw2, input logic ld,
                      input logic [7:0] data, input logic hlt, input logic [7:0] inp,
                      input logic [1:0] ia, input logic [1:0] ib);
    exp_t e;
    logic [7:0] wd;
    logic [1:0] dst;
    @(negedge clk);
    reset = 1'b1;
    wb_ra = ra; wb_rb = rb; wb_rw = rw; wb_sp = spop; wb_sw1 = sw1; wb_sw2 = sw2;
    wb_out_ld = ld; wb_data = data; wb_hlt = hlt; in_port = inp; rd_a_idx = ia; rd_b_idx = ib;
    wd  = sw2 ? inp : data;
    dst = sw1 ? rb : ra;
    e.a = ref_read(ia, rw, dst, wd);
    e.b = ref_read(ib, rw, dst, wd);
    e.s = m_r[3];
    e.o = m_out;
    e.h = m_h;
    q.push_back(e);
    if (!m_h) begin
      if (spop == 2'd1) m_r[3] = m_r[3] + 8'd1;
      if (spop == 2'd2) m_r[3] = m_r[3] - 8'd1;
      if (rw) m_r[dst] = wd;
      if (ld) m_out = data;
      if (hlt) m_h = 1'b1;
    end
  endtask

  task automatic do_reset(input logic [1:0] ia, input logic [1:0] ib);
    exp_t e;
    @(negedge clk);
    wb_ra = '0; wb_rb = '0; wb_rw = 1'b0; wb_sp = '0; wb_sw1 = 1'b0; wb_sw2 = 1'b0;
    wb_out_ld = 1'b0; wb_data = '0; wb_hlt = 1'b0; in_port = '0; rd_a_idx = ia; rd_b_idx = ib;
    reset = 1'b0;
    m_r[0] = 8'h00; m_r[1] = 8'h00; m_r[2] = 8'h00; m_r[3] = 8'hFF;
    m_out = 8'h00;
    m_h = 1'b0;
    e.a = m_r[ia];
    e.b = m_r[ib];
    e.s = m_r[3];
    e.o = m_out;
    e.h = m_h;
    q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs sampled 2ns after each driving edge, well before the next rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp("rd_a_data", rd_a_data, e.a);
        cmp("rd_b_data", rd_b_data, e.b);
        cmp("sp", sp, e.s);
        cmp("out_port", out_port, e.o);
        cmp("halted", {7'd0, halted}, {7'd0, e.h});
      end
    end
  end

  initial begin
    int waited;
    // reset and read all indices
    do_reset(2'd0, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd2, 2'd3);
    // write + bypass, then in_port write to R1 via wb_rb
    step(2, 0, 1, 0, 0, 0, 0, 8'h5A, 0, 8'h00, 2'd2, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd2, 2'd2);
    step(0, 1, 1, 0, 1, 1, 0, 8'h00, 0, 8'hC3, 2'd1, 2'd2);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd1, 2'd2);
    // SP wrap
    do_reset(2'd3, 2'd3);
    step(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 2'd3, 2'd0);
    step(0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 8'h00, 2'd3, 2'd0);
    step(0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 8'h00, 2'd3, 2'd0);
    step(0, 0, 0, 3, 0, 0, 0, 8'h00, 0, 8'h00, 2'd3, 2'd0);
    // write/SP conflict on R3
    step(3, 0, 1, 2, 0, 0, 0, 8'h40, 0, 8'h00, 2'd3, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd3, 2'd0);
    // output port takes wb_data, not in_port; bubble holds it
    step(0, 0, 0, 0, 0, 1, 1, 8'h99, 0, 8'h11, 2'd0, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 2'd1);
    // halt commits its own write, then blocks everything
    step(0, 0, 1, 0, 0, 0, 0, 8'h77, 1, 8'h00, 2'd0, 2'd3);
    step(0, 0, 1, 1, 0, 0, 1, 8'h22, 0, 8'h00, 2'd0, 2'd3);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 2'd3);
    do_reset(2'd0, 2'd3);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 2'd3);
    // randomized traffic with occasional halt and reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0)
        do_reset(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      else
        step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 39) == 0, 8'($urandom),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    waited = 0;
    while (q.size() != 0 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
